mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, the number of consecutive data grants allowed while a fetch is waiting.
REQ-002 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset; SHALL be asynchronous and active-low.
REQ-004 if_req  in  1  fetch request; SHALL be held until if_valid.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_flush  in  1  redirect; the pending fetch result SHALL be discarded.
REQ-007 if_rdata  out  32  fetched instruction.
REQ-008 if_valid  out  1  one-cycle pulse qualifying if_rdata.
REQ-009 imem_stall  out  1  fetch stall to the fetch stage.
REQ-010 d_req, d_we  in  1 each  data request and write-enable; both SHALL be held until d_valid.
REQ-011 d_addr, d_wdata  in  32 each  data address and write data.
REQ-012 d_be  in  4  data byte enables.
REQ-013 d_rdata  out  32  data read result.
REQ-014 d_valid  out  1  one-cycle completion pulse, asserted for both reads and writes.
REQ-015 dmem_stall  out  1  data stall.
REQ-016 mem_req, mem_we  out  1 each  shared-port request and write-enable.
REQ-017 mem_addr, mem_wdata  out  32 each  shared-port address and write data.
REQ-018 mem_be  out  4  shared-port byte enables.
REQ-019 mem_rdata  in  32  shared-port read data.
REQ-020 mem_ack  in  1  one-cycle completion from memory; may arrive any number of cycles (>=0) after mem_req rises.

Function
REQ-021 The FSM SHALL have four states: IDLE, IF_BUSY, D_BUSY and DONE.
REQ-022 IDLE, grant rules:
- only if_req high -> IF_BUSY;
- only d_req high -> D_BUSY;
- both high -> D_BUSY, unless starve_cnt == STARVE_LIMIT, then IF_BUSY.
REQ-023 On a grant, the winner's addr/wdata/be/we SHALL be registered onto mem_* and mem_req SHALL be set, both visible the next cycle; a fetch grant SHALL drive mem_we=0 and mem_be=4'hF.
REQ-024 mem_req and all mem_* outputs SHALL stay high/stable in IF_BUSY and D_BUSY until the cycle mem_ack is sampled, and SHALL go low on the following edge.
REQ-025 BUSY + mem_ack -> DONE, with mem_rdata registered into the owner's rdata.
REQ-026 DONE SHALL last exactly one cycle:
- owner's valid pulses high;
- requests are not sampled;
- next state is IDLE.
REQ-027 Minimum latency: req in IDLE at cycle 0, mem_req at cycle 1, mem_ack at cycle 1, valid at cycle 2.
REQ-028 starve_cnt (3 bits, saturating at STARVE_LIMIT) SHALL:
- increment on each data grant made while if_req is high;
- clear on each fetch grant;
- clear when if_req is sampled low in IDLE.
REQ-029 imem_stall = if_req & ~if_valid, combinational; dmem_stall = d_req & ~d_valid, combinational.
REQ-030 if_flush while in IF_BUSY or DONE:
- the bus transaction SHALL complete normally;
- if_valid SHALL be suppressed for that transaction, with a flush_pending flag set until DONE;
- if_rdata is not updated.
REQ-031 if_flush in IDLE or D_BUSY SHALL have no effect.
REQ-032 mem_ack outside IF_BUSY/D_BUSY SHALL be ignored.
REQ-033 if_rdata and d_rdata SHALL hold their last value between transactions.

Reset
REQ-034 rst low SHALL immediately force: state=IDLE, starve_cnt=0, flush_pending=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction with no valid pulse.
REQ-036 The first grant after reset release SHALL occur no earlier than the first rising edge with rst high.

Verification
REQ-037 Fetch-only: if_req, if_addr=0x100, mem_ack at cycle 1 with mem_rdata=0x00500093 -> if_valid and if_rdata=0x00500093 at cycle 2; imem_stall high in cycles 0-1.
REQ-038 Data write: d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011, ack after 3 wait cycles -> mem_* match the inputs throughout BUSY; d_valid pulses once; d_rdata unchanged.
REQ-039 Contention: if_req and d_req held continuously, STARVE_LIMIT=4 -> grant order is D,D,D,D,I,D,D,D,D,I; starve_cnt clears after each fetch grant.
REQ-040 Flush: if_flush pulsed while IF_BUSY, ack 2 cycles later -> mem_req drops after ack; no if_valid; if_rdata keeps its old value; the next fetch completes normally.
REQ-041 Async reset: rst low mid-way through D_BUSY, before the clock edge -> mem_req=0 and state=IDLE immediately; no d_valid; after release, a fresh d_req is granted on the next edge.
REQ-042 Spurious ack: mem_ack=1 in IDLE with no requests -> no state change and no valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// Data wins contention until a waiting fetch has been passed over STARVE_LIMIT times.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        imem_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        dmem_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, DONE} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state, state_next;
  logic [2:0] starve_cnt, starve_next;
  logic       flush_pending, flush_next;
  logic       owner_data, owner_next;
  logic       grant_if, grant_d;
  logic       busy_ack;

  assign busy_ack = ((state == IF_BUSY) || (state == D_BUSY)) && mem_ack;

  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    flush_next  = flush_pending;
    owner_next  = owner_data;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(if_req && (starve_cnt >= LIMIT))) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
        if (grant_d) begin
          state_next = D_BUSY;
          owner_next = 1'b1;
        end
        if (grant_if) begin
          state_next = IF_BUSY;
          owner_next = 1'b0;
        end
        if (!if_req || grant_if) begin
          starve_next = 3'd0;
        end else if (grant_d && (starve_cnt < LIMIT)) begin
          starve_next = starve_cnt + 3'd1;
        end
      end
      IF_BUSY: begin
        if (if_flush) flush_next = 1'b1;
        if (mem_ack) state_next = DONE;
      end
      D_BUSY: begin
        if (mem_ack) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        flush_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      starve_cnt    <= 3'd0;
      flush_pending <= 1'b0;
      owner_data    <= 1'b0;
    end else begin
      state         <= state_next;
      starve_cnt    <= starve_next;
      flush_pending <= flush_next;
      owner_data    <= owner_next;
    end
  end

  // Shared-port command is latched at grant and held untouched until the ack edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
    end else if (grant_d) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_be;
    end else if (grant_if) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= 32'd0;
      mem_be    <= 4'hF;
    end else if (busy_ack) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
    end
  end

  // A flush arriving on the ack cycle itself must also keep the stale word out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      if ((state == IF_BUSY) && mem_ack && !flush_pending && !if_flush) begin
        if_rdata <= mem_rdata;
      end
      if ((state == D_BUSY) && mem_ack && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

  assign if_valid   = (state == DONE) && !owner_data && !flush_pending && !if_flush;
  assign d_valid    = (state == DONE) && owner_data;
  assign imem_stall = if_req & ~if_valid;
  assign dmem_stall = d_req & ~d_valid;

endmodule
